// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Shares CDB_WIDTH common-data-bus lanes among NUM_FU writeback
//            requesters. Up to CDB_WIDTH valid requesters are granted per
//            cycle in round-robin order. Their payloads are registered onto
//            the lanes, one cycle after the grant.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            fu_valid/ready   - per-requester handshake (ready = granted now)
//            fu_rob_id, fu_rd_phy, fu_rd_arch, fu_rd_we, fu_rd_data
//                             - per-requester result payload (slice i)
//            cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_we,
//            cdb_rd_data      - registered lane outputs (slice k = lane k)
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int NUM_FU    = 4,
   parameter int CDB_WIDTH = 2,
   parameter int ROB_IDX   = 5,
   parameter int PRF_IDX   = 6,
   parameter int ARF_IDX   = 5,
   parameter int DATA_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_FU-1:0]             fu_valid,
   output logic [NUM_FU-1:0]             fu_ready,
   input  logic [NUM_FU*ROB_IDX-1:0]     fu_rob_id,
   input  logic [NUM_FU*PRF_IDX-1:0]     fu_rd_phy,
   input  logic [NUM_FU*ARF_IDX-1:0]     fu_rd_arch,
   input  logic [NUM_FU-1:0]             fu_rd_we,
   input  logic [NUM_FU*DATA_W-1:0]      fu_rd_data,
   output logic [CDB_WIDTH-1:0]          cdb_valid,
   output logic [CDB_WIDTH*ROB_IDX-1:0]  cdb_rob_id,
   output logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy,
   output logic [CDB_WIDTH*ARF_IDX-1:0]  cdb_rd_arch,
   output logic [CDB_WIDTH-1:0]          cdb_rd_we,
   output logic [CDB_WIDTH*DATA_W-1:0]   cdb_rd_data
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [PTR_W-1:0]             rr_ptr_q,      rr_ptr_d;
   logic [CDB_WIDTH-1:0]         cdb_valid_q,   cdb_valid_d;
   logic [CDB_WIDTH*ROB_IDX-1:0] cdb_rob_id_q,  cdb_rob_id_d;
   logic [CDB_WIDTH*PRF_IDX-1:0] cdb_rd_phy_q,  cdb_rd_phy_d;
   logic [CDB_WIDTH*ARF_IDX-1:0] cdb_rd_arch_q, cdb_rd_arch_d;
   logic [CDB_WIDTH-1:0]         cdb_rd_we_q,   cdb_rd_we_d;
   logic [CDB_WIDTH*DATA_W-1:0]  cdb_rd_data_q, cdb_rd_data_d;

   logic [NUM_FU-1:0] grant;
   int                pos  [NUM_FU];  // distance of requester i from rr_ptr in scan order
   int                rank [NUM_FU];  // number of valid requesters scanned before i
   int                last_pos;
   int                last_idx;
   int                nxt;

   // A requester's lane is its rank among valid requesters in scan order;
   // it is granted when that rank fits in the lane count. This gives
   // contiguous lane fill from lane 0 without a sequential scan chain.
   always_comb begin
      grant         = '0;
      cdb_valid_d   = '0;
      cdb_rob_id_d  = '0;
      cdb_rd_phy_d  = '0;
      cdb_rd_arch_d = '0;
      cdb_rd_we_d   = '0;
      cdb_rd_data_d = '0;
      rr_ptr_d      = rr_ptr_q;
      last_pos      = -1;
      last_idx      = 0;
      nxt           = 0;

      for (int i = 0; i < NUM_FU; i++) begin
         pos[i] = i - int'(rr_ptr_q);
         if (pos[i] < 0) begin
            pos[i] = pos[i] + NUM_FU;
         end
      end

      for (int i = 0; i < NUM_FU; i++) begin
         rank[i] = 0;
         for (int m = 0; m < NUM_FU; m++) begin
            if (fu_valid[m] && (pos[m] < pos[i])) begin
               rank[i] = rank[i] + 1;
            end
         end
         grant[i] = fu_valid[i] && (rank[i] < CDB_WIDTH);
      end

      for (int j = 0; j < CDB_WIDTH; j++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i] && (rank[i] == j)) begin
               cdb_valid_d[j]                        = 1'b1;
               cdb_rob_id_d [j*ROB_IDX +: ROB_IDX]   = fu_rob_id [i*ROB_IDX +: ROB_IDX];
               cdb_rd_phy_d [j*PRF_IDX +: PRF_IDX]   = fu_rd_phy [i*PRF_IDX +: PRF_IDX];
               cdb_rd_arch_d[j*ARF_IDX +: ARF_IDX]   = fu_rd_arch[i*ARF_IDX +: ARF_IDX];
               cdb_rd_we_d[j]                        = fu_rd_we[i];
               cdb_rd_data_d[j*DATA_W +: DATA_W]     = fu_rd_data[i*DATA_W +: DATA_W];
            end
         end
      end

      // The last granted requester is the one furthest along the scan.
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i] && (pos[i] > last_pos)) begin
            last_pos = pos[i];
            last_idx = i;
         end
      end
      if (last_pos >= 0) begin
         nxt = last_idx + 1;
         if (nxt == NUM_FU) begin
            nxt = 0;
         end
         rr_ptr_d = nxt[PTR_W-1:0];
      end
   end

   // No handshake completes during reset, so nothing is lost or duplicated.
   assign fu_ready = grant & {NUM_FU{~rst}};

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         cdb_valid_q   <= '0;
         cdb_rob_id_q  <= '0;
         cdb_rd_phy_q  <= '0;
         cdb_rd_arch_q <= '0;
         cdb_rd_we_q   <= '0;
         cdb_rd_data_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         cdb_valid_q   <= cdb_valid_d;
         cdb_rob_id_q  <= cdb_rob_id_d;
         cdb_rd_phy_q  <= cdb_rd_phy_d;
         cdb_rd_arch_q <= cdb_rd_arch_d;
         cdb_rd_we_q   <= cdb_rd_we_d;
         cdb_rd_data_q <= cdb_rd_data_d;
      end
   end

   assign cdb_valid   = cdb_valid_q;
   assign cdb_rob_id  = cdb_rob_id_q;
   assign cdb_rd_phy  = cdb_rd_phy_q;
   assign cdb_rd_arch = cdb_rd_arch_q;
   assign cdb_rd_we   = cdb_rd_we_q;
   assign cdb_rd_data = cdb_rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter (NUM_FU=4, CDB_WIDTH=2).
//            A cycle-level reference model predicts grants and lane
//            contents. A negedge process compares every cycle, and directed
//            literal checks pin the key scenarios.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   localparam int NUM_FU    = 4;
   localparam int CDB_WIDTH = 2;
   localparam int ROB_IDX   = 5;
   localparam int PRF_IDX   = 6;
   localparam int ARF_IDX   = 5;
   localparam int DATA_W    = 32;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU-1:0]             fu_ready;
   logic [NUM_FU*ROB_IDX-1:0]     fu_rob_id;
   logic [NUM_FU*PRF_IDX-1:0]     fu_rd_phy;
   logic [NUM_FU*ARF_IDX-1:0]     fu_rd_arch;
   logic [NUM_FU-1:0]             fu_rd_we;
   logic [NUM_FU*DATA_W-1:0]      fu_rd_data;
   logic [CDB_WIDTH-1:0]          cdb_valid;
   logic [CDB_WIDTH*ROB_IDX-1:0]  cdb_rob_id;
   logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy;
   logic [CDB_WIDTH*ARF_IDX-1:0]  cdb_rd_arch;
   logic [CDB_WIDTH-1:0]          cdb_rd_we;
   logic [CDB_WIDTH*DATA_W-1:0]   cdb_rd_data;

   // per-requester payload
   logic [ROB_IDX-1:0] p_rob  [NUM_FU];
   logic [PRF_IDX-1:0] p_phy  [NUM_FU];
   logic [ARF_IDX-1:0] p_arch [NUM_FU];
   logic               p_we   [NUM_FU];
   logic [DATA_W-1:0]  p_data [NUM_FU];

   always_comb begin
      fu_rob_id  = '0;
      fu_rd_phy  = '0;
      fu_rd_arch = '0;
      fu_rd_we   = '0;
      fu_rd_data = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_rob_id [i*ROB_IDX +: ROB_IDX] = p_rob[i];
         fu_rd_phy [i*PRF_IDX +: PRF_IDX] = p_phy[i];
         fu_rd_arch[i*ARF_IDX +: ARF_IDX] = p_arch[i];
         fu_rd_we[i]                      = p_we[i];
         fu_rd_data[i*DATA_W +: DATA_W]   = p_data[i];
      end
   end

   cdb_arbiter #(
      .NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .ROB_IDX(ROB_IDX),
      .PRF_IDX(PRF_IDX), .ARF_IDX(ARF_IDX), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_rob_id(fu_rob_id), .fu_rd_phy(fu_rd_phy), .fu_rd_arch(fu_rd_arch),
      .fu_rd_we(fu_rd_we), .fu_rd_data(fu_rd_data),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
      .cdb_rd_arch(cdb_rd_arch), .cdb_rd_we(cdb_rd_we), .cdb_rd_data(cdb_rd_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                 m_ptr;
   bit                 model_ok = 1'b0;
   logic               e_valid [CDB_WIDTH];
   logic [ROB_IDX-1:0] e_rob   [CDB_WIDTH];
   logic [PRF_IDX-1:0] e_phy   [CDB_WIDTH];
   logic [ARF_IDX-1:0] e_arch  [CDB_WIDTH];
   logic               e_we    [CDB_WIDTH];
   logic [DATA_W-1:0]  e_data  [CDB_WIDTH];

   // Requesters granted this cycle, listed in round-robin scan order.
   function automatic void scan_order(input logic [NUM_FU-1:0] v, input int ptr,
                                      output int q [$]);
      q = {};
      for (int k = 0; k < NUM_FU; k++) begin
         if (v[(ptr + k) % NUM_FU] && (q.size() < CDB_WIDTH)) begin
            q.push_back((ptr + k) % NUM_FU);
         end
      end
   endfunction

   function automatic logic [NUM_FU-1:0] model_ready();
      int q [$];
      logic [NUM_FU-1:0] r = '0;
      if (!rst) begin
         scan_order(fu_valid, m_ptr, q);
         foreach (q[n]) r[q[n]] = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      int q [$];
      for (int j = 0; j < CDB_WIDTH; j++) begin
         e_valid[j] = 1'b0; e_rob[j] = '0; e_phy[j] = '0;
         e_arch[j]  = '0;   e_we[j]  = 1'b0; e_data[j] = '0;
      end
      if (rst) begin
         m_ptr    = 0;
         model_ok = 1'b1;
      end else begin
         scan_order(fu_valid, m_ptr, q);
         foreach (q[n]) begin
            e_valid[n] = 1'b1;
            e_rob[n]   = p_rob[q[n]];
            e_phy[n]   = p_phy[q[n]];
            e_arch[n]  = p_arch[q[n]];
            e_we[n]    = p_we[q[n]];
            e_data[n]  = p_data[q[n]];
         end
         if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % NUM_FU;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         check("fu_ready", 64'(fu_ready), 64'(model_ready()));
         for (int j = 0; j < CDB_WIDTH; j++) begin
            check("cdb_valid", 64'(cdb_valid[j]),                       64'(e_valid[j]));
            check("cdb_rob",   64'(cdb_rob_id[j*ROB_IDX +: ROB_IDX]),   64'(e_rob[j]));
            check("cdb_phy",   64'(cdb_rd_phy[j*PRF_IDX +: PRF_IDX]),   64'(e_phy[j]));
            check("cdb_arch",  64'(cdb_rd_arch[j*ARF_IDX +: ARF_IDX]),  64'(e_arch[j]));
            check("cdb_we",    64'(cdb_rd_we[j]),                       64'(e_we[j]));
            check("cdb_data",  64'(cdb_rd_data[j*DATA_W +: DATA_W]),    64'(e_data[j]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ROB_IDX-1:0] lane_rob(input int j);
      return cdb_rob_id[j*ROB_IDX +: ROB_IDX];
   endfunction

   int got   [NUM_FU];
   int grants[NUM_FU];

   initial begin
      rst      = 1'b1;
      fu_valid = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         p_rob[i]  = ROB_IDX'(8 + i);
         p_phy[i]  = PRF_IDX'(32 + i);
         p_arch[i] = ARF_IDX'(i + 1);
         p_we[i]   = i[0];
         p_data[i] = 32'hA000_0000 + i;
         grants[i] = 0;
         got[i]    = 0;
      end
      tick();

      // 1. reset with all requesters valid
      fu_valid = 4'b1111;
      repeat (2) begin
         @(negedge clk);
         check("rst_ready", 64'(fu_ready), 64'h0);
         tick();
      end
      rst = 1'b0;

      // 1/3. first cycle after release: lanes empty, rr_ptr=0 -> FU0,FU1
      @(negedge clk);
      check("post_rst_valid", 64'(cdb_valid), 64'h0);
      check("sat0_ready",     64'(fu_ready),  64'b0011);
      tick();
      p_rob[0] = 5'd20;
      p_rob[1] = 5'd21;
      @(negedge clk);
      check("sat1_ready", 64'(fu_ready),  64'b1100);
      check("sat1_valid", 64'(cdb_valid), 64'b11);
      check("sat1_lane0", 64'(lane_rob(0)), 64'd8);
      check("sat1_lane1", 64'(lane_rob(1)), 64'd9);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      check("sat2_ready", 64'(fu_ready),  64'b0000);
      check("sat2_lane0", 64'(lane_rob(0)), 64'd10);
      check("sat2_lane1", 64'(lane_rob(1)), 64'd11);
      tick();

      // 2. single request from FU2
      p_rob[2] = 5'd5; p_phy[2] = 6'd17; p_data[2] = 32'hDEADBEEF;
      fu_valid = 4'b0100;
      @(negedge clk);
      check("single_ready", 64'(fu_ready),  64'b0100);
      check("idle_valid",   64'(cdb_valid), 64'b00);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      check("single_valid", 64'(cdb_valid), 64'b01);
      check("single_rob",   64'(lane_rob(0)), 64'd5);
      check("single_phy",   64'(cdb_rd_phy[PRF_IDX-1:0]), 64'd17);
      check("single_data",  64'(cdb_rd_data[DATA_W-1:0]), 64'hDEADBEEF);
      check("lane1_rob0",   64'(lane_rob(1)), 64'd0);
      check("lane1_data0",  64'(cdb_rd_data[2*DATA_W-1:DATA_W]), 64'd0);
      tick();

      // 4. wrap-around from rr_ptr=3
      fu_valid = 4'b1001;
      @(negedge clk);
      check("wrap_ready", 64'(fu_ready), 64'b1001);
      tick();
      fu_valid = 4'b0111;   // rr_ptr=1 must pick FU1,FU2
      @(negedge clk);
      check("wrap_lane0", 64'(lane_rob(0)), 64'd11);
      check("wrap_lane1", 64'(lane_rob(1)), 64'd20);
      check("ptr1_ready", 64'(fu_ready), 64'b0110);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      check("ptr1_lane0", 64'(lane_rob(0)), 64'd21);
      check("ptr1_lane1", 64'(lane_rob(1)), 64'd5);
      tick();

      // 5. fairness: FU0 always valid, FU1..FU3 raised once, held until ready
      for (int i = 1; i < NUM_FU; i++) p_rob[i] = ROB_IDX'(24 + i);
      for (int c = 0; c < 5; c++) begin
         fu_valid[0] = 1'b1;
         for (int i = 1; i < NUM_FU; i++) begin
            if (c == 0) fu_valid[i] = 1'b1;
            else if (got[i] != 0) fu_valid[i] = 1'b0;
            got[i] = 0;
         end
         @(negedge clk);
         if (c == 0) check("fair0_ready", 64'(fu_ready), 64'b1001);
         if (c == 1) check("fair1_ready", 64'(fu_ready), 64'b0110);
         for (int i = 1; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
               got[i] = 1;
               grants[i]++;
               check("fair_wait_ok", 64'(c < 2), 64'd1);
            end
         end
         tick();
      end
      for (int i = 1; i < NUM_FU; i++) check("fair_grant_once", 64'(grants[i]), 64'd1);

      // 6. reset the cycle after a 2-lane grant
      fu_valid = 4'b1111;
      @(negedge clk);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_ready", 64'(fu_ready),  64'b0000);
      check("rstmid_valid", 64'(cdb_valid), 64'b11);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_after_valid", 64'(cdb_valid), 64'b00);
      check("rstmid_after_ready", 64'(fu_ready),  64'b0011);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      check("regrant_valid", 64'(cdb_valid), 64'b11);
      check("regrant_lane0", 64'(lane_rob(0)), 64'd20);
      check("regrant_lane1", 64'(lane_rob(1)), 64'd25);
      tick();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
